// File: rtl/mc_dispatcher_pkg.sv
// rtl/mc_dispatcher_pkg.sv - shared types and helpers for the multi-channel dispatcher
package mc_dispatcher_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Channel field sized for the 16-channel maximum; unused upper bits stay zero.
  typedef struct packed {
    logic [3:0]  ch;
    logic [15:0] seq;
  } hdr_t;

  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mc_dispatcher_if.sv
// rtl/mc_dispatcher_if.sv - TX stream bundle from the dispatcher towards the NoC router
interface mc_dispatcher_if #(
  parameter int DATAW = 512,
  parameter int USERW = 75,
  parameter int BYTEW = 8,
  parameter int IDW   = 32,
  parameter int DESTW = 7
);
  logic                   tvalid;
  logic                   tready;
  logic [DATAW+USERW-1:0] tdata;
  logic [BYTEW-1:0]       tstrb;
  logic [BYTEW-1:0]       tkeep;
  logic [IDW-1:0]         tid;
  logic [DESTW-1:0]       tdest;
  logic [USERW-1:0]       tuser;
  logic                   tlast;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/mc_dispatcher_fifo.sv
// rtl/mc_dispatcher_fifo.sv - per-channel first-word-fall-through storage
// Fill level is tracked by the owner, which never pushes when full or pops when empty.
module mc_dispatcher_fifo #(
  parameter int DATAW = 512,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DATAW-1:0] wdata,
  input  logic             pop,
  output logic [DATAW-1:0] rdata
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
endmodule

// File: rtl/mc_dispatcher_rr_arbiter.sv
// rtl/mc_dispatcher_rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
module mc_dispatcher_rr_arbiter
  import mc_dispatcher_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = chw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Two passes: requesters at/above ptr first, then wrap to the low ones.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (IW'(i) >= ptr)) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (IW'(i) == idx);
    end
  end
endmodule

// File: rtl/mc_dispatcher.sv
// rtl/mc_dispatcher.sv - drains NUM_CH push FIFOs as round-robin wormhole packets onto one TX stream
module mc_dispatcher
  import mc_dispatcher_pkg::*;
#(
  parameter int DATAW      = 512,
  parameter int BYTEW      = 8,
  parameter int IDW        = 32,
  parameter int DESTW      = 7,
  parameter int USERW      = 75,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 64,
  parameter int BURST_LEN  = 8,
  parameter int RDY_MARGIN = 4,
  parameter logic [NUM_CH*DESTW-1:0] DESTNODES = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_wen,
  input  logic [NUM_CH*DATAW-1:0] ch_wdata,
  output logic [NUM_CH-1:0]       ch_rdy,
  output logic [NUM_CH-1:0]       ovf_err,
  mc_dispatcher_if.master         axis_tx
);
  localparam int CHW  = chw(NUM_CH);
  localparam int OCCW = $clog2(DEPTH + 1);
  localparam int BCW  = chw(BURST_LEN);

  state_e            state, state_n;
  logic [CHW-1:0]    grant, grant_n;
  logic [CHW-1:0]    rr_ptr, rr_n;
  logic [BCW-1:0]    beat_cnt, beat_n;
  logic [CHW-1:0]    pop_ch;
  logic              do_pop;
  logic              pop_last;
  logic [NUM_CH-1:0] pop_vec;

  logic [OCCW-1:0]   occ [NUM_CH];
  logic [15:0]       pkt_seq [NUM_CH];
  logic [DATAW-1:0]  fifo_rdata [NUM_CH];
  logic [DESTW-1:0]  dest_tab [NUM_CH];
  logic [NUM_CH-1:0] push_ok;
  logic [NUM_CH-1:0] req;

  logic [NUM_CH-1:0] arb_gnt;
  logic [CHW-1:0]    arb_idx;
  logic              arb_any;

  logic              tvalid_q;
  logic              tlast_q;
  logic [DATAW-1:0]  data_q;
  logic [USERW-1:0]  hdr_q;
  logic [IDW-1:0]    tid_q;
  logic [DESTW-1:0]  tdest_q;
  logic              out_ready;
  hdr_t              hdr_c;

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
    return (c == CHW'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dest_tab[i] = DESTNODES[i*DESTW +: DESTW];
      push_ok[i]  = ch_wen[i] && (occ[i] != OCCW'(DEPTH));
      req[i]      = (occ[i] != '0);
      ch_rdy[i]   = (occ[i] < OCCW'(DEPTH - RDY_MARGIN));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    mc_dispatcher_fifo #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok[g]),
      .wdata (ch_wdata[g*DATAW +: DATAW]),
      .pop   (pop_vec[g]),
      .rdata (fifo_rdata[g])
    );
  end

  mc_dispatcher_rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign out_ready = ~tvalid_q | axis_tx.tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      rr_ptr   <= rr_n;
      beat_cnt <= beat_n;
    end
  end

  // A packet ends at BURST_LEN beats or when the popped word is the last one
  // stored; a push landing in the same cycle belongs to the next packet.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    rr_n     = rr_ptr;
    beat_n   = beat_cnt;
    do_pop   = 1'b0;
    pop_last = 1'b0;
    pop_ch   = grant;
    pop_vec  = '0;
    case (state)
      IDLE: begin
        pop_ch = arb_idx;
        if (out_ready && arb_any) begin
          do_pop   = 1'b1;
          pop_vec  = arb_gnt;
          pop_last = (BURST_LEN == 1) || (occ[arb_idx] == OCCW'(1));
          if (pop_last) begin
            rr_n = next_ch(arb_idx);
          end else begin
            state_n = BURST;
            grant_n = arb_idx;
            beat_n  = BCW'(1);
          end
        end
      end
      BURST: begin
        if (out_ready && (occ[grant] != '0)) begin
          do_pop   = 1'b1;
          pop_last = (beat_cnt == BCW'(BURST_LEN - 1)) || (occ[grant] == OCCW'(1));
          for (int i = 0; i < NUM_CH; i++) begin
            pop_vec[i] = (CHW'(i) == grant);
          end
          if (pop_last) begin
            state_n = IDLE;
            rr_n    = next_ch(grant);
            beat_n  = '0;
          end else begin
            beat_n = beat_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_err <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        occ[i]     <= '0;
        pkt_seq[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_ok[i] && !pop_vec[i]) begin
          occ[i] <= occ[i] + 1'b1;
        end else if (!push_ok[i] && pop_vec[i]) begin
          occ[i] <= occ[i] - 1'b1;
        end
        if (ch_wen[i] && !push_ok[i]) ovf_err[i] <= 1'b1;
        if (pop_vec[i] && pop_last) pkt_seq[i] <= pkt_seq[i] + 1'b1;
      end
    end
  end

  // Sequence number only advances on the last pop, so it is stable across a packet.
  always_comb begin
    hdr_c.ch  = 4'(pop_ch);
    hdr_c.seq = pkt_seq[pop_ch];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      data_q   <= '0;
      hdr_q    <= '0;
      tid_q    <= '0;
      tdest_q  <= '0;
    end else if (do_pop) begin
      tvalid_q <= 1'b1;
      tlast_q  <= pop_last;
      data_q   <= fifo_rdata[pop_ch];
      hdr_q    <= USERW'(hdr_c);
      tid_q    <= IDW'(pop_ch);
      tdest_q  <= dest_tab[pop_ch];
    end else if (axis_tx.tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign axis_tx.tvalid = tvalid_q;
  assign axis_tx.tdata  = {hdr_q, data_q};
  assign axis_tx.tstrb  = {BYTEW{tvalid_q}};
  assign axis_tx.tkeep  = {BYTEW{tvalid_q}};
  assign axis_tx.tid    = tid_q;
  assign axis_tx.tdest  = tdest_q;
  assign axis_tx.tuser  = hdr_q;
  assign axis_tx.tlast  = tlast_q;
endmodule

// File: tb/tb_mc_dispatcher.sv
// tb/tb_mc_dispatcher.sv - randomized self-checking bench for mc_dispatcher
module tb_mc_dispatcher;
  localparam int DATAW = 32, USERW = 24, BYTEW = 4, IDW = 8, DESTW = 7;
  localparam int NUM_CH = 4, DEPTH = 64, BURST_LEN = 8, RDY_MARGIN = 4;
  localparam logic [NUM_CH*DESTW-1:0] DESTNODES = {7'd99, 7'd42, 7'd21, 7'd10};
  localparam int DEST_OF [NUM_CH] = '{10, 21, 42, 99};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_CH-1:0]       ch_wen = '0;
  logic [NUM_CH*DATAW-1:0] ch_wdata = '0;
  logic [NUM_CH-1:0]       ch_rdy;
  logic [NUM_CH-1:0]       ovf_err;

  mc_dispatcher_if #(.DATAW(DATAW), .USERW(USERW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW)) axis_tx ();

  mc_dispatcher #(
    .DATAW(DATAW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW),
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .RDY_MARGIN(RDY_MARGIN),
    .DESTNODES(DESTNODES)
  ) dut (
    .clk(clk), .rst(rst), .ch_wen(ch_wen), .ch_wdata(ch_wdata),
    .ch_rdy(ch_rdy), .ovf_err(ovf_err), .axis_tx(axis_tx)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int len; } pkt_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tready_mode = 1;
  logic [DATAW-1:0] exp_q [NUM_CH][$];
  int seq_m [NUM_CH];
  pkt_t pkt_log[$];
  pkt_t exp_pkts[$];
  int acc_cyc[$];
  int cur_len = 0;
  int cur_ch = 0;
  int beats = 0;
  int first_valid_cyc = -1;
  bit stall_prev = 0;
  logic [63:0] s_data;
  logic [63:0] s_ctl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] acc);
    logic [DATAW-1:0] w;
    for (int i = 0; i < NUM_CH; i++) begin
      w = $urandom;
      ch_wdata[i*DATAW +: DATAW] = w;
      if (mask[i] && acc[i]) exp_q[i].push_back(w);
    end
    ch_wen = mask;
    tick();
    ch_wen = '0;
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < NUM_CH; i++) if (exp_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((!model_empty() || axis_tx.tvalid) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, n < budget, 1);
  endtask

  task automatic add_pkts(input int ch, input int len, input int cnt);
    pkt_t p;
    p.ch = ch;
    p.len = len;
    repeat (cnt) exp_pkts.push_back(p);
  endtask

  task automatic check_pkts(input string tag);
    check({tag, "_npkts"}, pkt_log.size(), exp_pkts.size());
    for (int i = 0; i < exp_pkts.size() && i < pkt_log.size(); i++) begin
      check($sformatf("%s_pkt%0d_ch", tag, i), pkt_log[i].ch, exp_pkts[i].ch);
      check($sformatf("%s_pkt%0d_len", tag, i), pkt_log[i].len, exp_pkts[i].len);
    end
    pkt_log.delete();
    exp_pkts.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_q[i].delete();
      seq_m[i] = 0;
    end
    cur_len = 0;
    pkt_log.delete();
  endtask

  task automatic accept_beat();
    int ch;
    logic [DATAW-1:0] w;
    logic [USERW-1:0] eu;
    ch = int'(axis_tx.tid);
    check("tid_range", ch < NUM_CH, 1);
    if (ch < NUM_CH) begin
      if (cur_len > 0) check("wormhole_ch", ch, cur_ch);
      cur_ch = ch;
      w = '0;
      check("beat_expected", exp_q[ch].size() > 0, 1);
      if (exp_q[ch].size() > 0) w = exp_q[ch].pop_front();
      eu = USERW'((ch << 16) + seq_m[ch]);
      check("tdata", axis_tx.tdata, {eu, w});
      check("tuser", axis_tx.tuser, eu);
      check("tdest", axis_tx.tdest, DEST_OF[ch]);
      check("tstrb_tkeep", {axis_tx.tstrb, axis_tx.tkeep}, 8'hFF);
      cur_len++;
      check("burst_max", cur_len <= BURST_LEN, 1);
      if (axis_tx.tlast) begin
        pkt_log.push_back('{ch, cur_len});
        seq_m[ch] = (seq_m[ch] + 1) % 65536;
        cur_len = 0;
      end
    end
    beats++;
    acc_cyc.push_back(cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    axis_tx.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0: axis_tx.tready = 1'b0;
        1: axis_tx.tready = 1'b1;
        default: axis_tx.tready = 1'($urandom % 2);
      endcase
    end
  end

  // Sink-side monitor; negedge sampling sees the values the next rising edge will act on.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      stall_prev = 0;
    end else begin
      if (axis_tx.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (axis_tx.tvalid && !axis_tx.tready) begin
        if (stall_prev) begin
          check("stall_tdata", axis_tx.tdata, s_data);
          check("stall_ctl", {axis_tx.tdest, axis_tx.tid, axis_tx.tlast}, s_ctl);
        end
        stall_prev = 1;
        s_data = 64'(axis_tx.tdata);
        s_ctl = 64'({axis_tx.tdest, axis_tx.tid, axis_tx.tlast});
      end else begin
        stall_prev = 0;
      end
      if (axis_tx.tvalid && axis_tx.tready) accept_beat();
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int t0;
    int b0;
    for (int i = 0; i < NUM_CH; i++) seq_m[i] = 0;
    tready_mode = 1;
    tick(3);
    rst = 1'b1;
    check("rst_tvalid", axis_tx.tvalid, 0);
    check("rst_tdata", axis_tx.tdata, 0);
    check("rst_tlast", axis_tx.tlast, 0);
    check("rst_tid", axis_tx.tid, 0);
    check("rst_tdest", axis_tx.tdest, 0);
    check("rst_tuser", axis_tx.tuser, 0);
    check("rst_tstrb", axis_tx.tstrb, 0);
    check("rst_ch_rdy", ch_rdy, 4'hF);
    check("rst_ovf", ovf_err, 0);

    // Streaming pushes to ch2: each pop sees a single stored word.
    first_valid_cyc = -1;
    t0 = cyc;
    b0 = beats;
    repeat (3) push(4'b0100, 4'b0100);
    drain("t1", 50);
    check("t1_latency", first_valid_cyc - t0, 2);
    check("t1_beats", beats - b0, 3);
    add_pkts(2, 1, 3);
    check_pkts("t1");

    // Blocker beat parks in the output register so all channels fill before draining.
    for (int pass = 0; pass < 2; pass++) begin
      tready_mode = 0;
      tick(2);
      push(4'b1000, 4'b1000);
      repeat (20) push(4'hF, 4'hF);
      acc_cyc.delete();
      tready_mode = (pass == 0) ? 1 : 2;
      drain(pass == 0 ? "t2" : "t3", 1500);
      if (pass == 0) begin
        check("t2_nbeats", acc_cyc.size(), 81);
        if (acc_cyc.size() == 81) check("t2_no_gaps", acc_cyc[80] - acc_cyc[0], 80);
      end
      add_pkts(3, 1, 1);
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < NUM_CH; c++) add_pkts(c, 8, 1);
      for (int c = 0; c < NUM_CH; c++) add_pkts(c, 4, 1);
      check_pkts(pass == 0 ? "t2" : "t3");
    end

    // Fill ch1 with the sink stalled: first word goes to the register, the rest stay queued.
    tready_mode = 0;
    tick(2);
    for (int k = 1; k <= 66; k++) begin
      push(4'b0010, (k <= 65) ? 4'b0010 : 4'b0000);
      check($sformatf("t4_rdy_k%0d", k), ch_rdy, (k <= 60) ? 4'hF : 4'hD);
      check($sformatf("t4_ovf_k%0d", k), ovf_err, (k > 65) ? 4'h2 : 4'h0);
    end
    b0 = beats;
    tready_mode = 1;
    drain("t4", 500);
    check("t4_beats", beats - b0, 65);
    check("t4_ovf_sticky", ovf_err, 4'h2);
    check("t4_rdy_after", ch_rdy, 4'hF);
    add_pkts(1, 1, 1);
    add_pkts(1, 8, 8);
    check_pkts("t4");

    // Trickle ch3.
    tready_mode = 1;
    repeat (6) begin
      push(4'b1000, 4'b1000);
      tick(2);
    end
    drain("t5", 50);
    add_pkts(3, 1, 6);
    check_pkts("t5");

    // Reset in the middle of a ch0 burst.
    tready_mode = 0;
    tick(2);
    repeat (10) push(4'b0001, 4'b0001);
    tready_mode = 1;
    tick(4);
    do_reset();
    check("t6_tvalid", axis_tx.tvalid, 0);
    check("t6_ch_rdy", ch_rdy, 4'hF);
    check("t6_ovf", ovf_err, 0);
    b0 = beats;
    tick(20);
    check("t6_quiet_beats", beats - b0, 0);
    check("t6_quiet_tvalid", axis_tx.tvalid, 0);
    repeat (2) push(4'b0001, 4'b0001);
    drain("t6", 50);
    add_pkts(0, 1, 2);
    check_pkts("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
